// File: rtl/gray_counter_sched.sv
// Two-requester round-robin scheduler that runs bursts of Gray-code steps
// on a shared 3-bit counter; one counter step every STEP_DIV cycles.
//
// state  | meaning
// S_IDLE | no burst; arbitrate on the next edge with req != 00
// S_RUN  | burst granted, stepping count every STEP_DIV cycles
// S_DONE | final step registered; done pulse, then release the grant
module gray_counter_sched #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [2:0] len0,
  input  logic [2:0] len1,
  input  logic [1:0] dir,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [2:0] count,
  output logic [1:0] done,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] DIV_LOAD = 4'(STEP_DIV - 1);

  state_t     r_state;
  logic [1:0] r_gnt;
  logic       r_busy;
  logic [2:0] r_count;
  logic [1:0] r_done;
  logic       r_wrap;
  logic       r_last;
  logic       r_dir;
  logic [2:0] r_left;
  logic [3:0] r_div;

  logic [2:0] w_bin;
  logic [2:0] w_bin_nxt;
  logic [2:0] w_gray_nxt;
  logic       w_wrap_nxt;
  logic       w_win;

  assign w_bin      = {r_count[2], r_count[2] ^ r_count[1], ^r_count};
  assign w_bin_nxt  = r_dir ? (w_bin - 3'd1) : (w_bin + 3'd1);
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  assign w_wrap_nxt = r_dir ? (w_bin == 3'd0) : (w_bin == 3'd7);

  // r_last holds the index of the requester served last; on a tie the other one wins
  assign w_win = (req == 2'b11) ? ~r_last : req[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_busy  <= 1'b0;
      r_count <= 3'b000;
      r_done  <= 2'b00;
      r_wrap  <= 1'b0;
      r_last  <= 1'b1;
      r_dir   <= 1'b0;
      r_left  <= 3'd0;
      r_div   <= 4'd0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_done <= 2'b00;
          if (req != 2'b00) begin
            r_state <= S_RUN;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_left  <= w_win ? len1 : len0;
            r_dir   <= dir[w_win];
            r_div   <= DIV_LOAD;
          end
        end
        S_RUN: begin
          if (r_div == 4'd0) begin
            r_count <= w_gray_nxt;
            r_wrap  <= w_wrap_nxt;
            r_div   <= DIV_LOAD;
            if (r_left == 3'd0) begin
              r_state <= S_DONE;
              r_done  <= r_gnt;
            end else begin
              r_left <= r_left - 3'd1;
            end
          end else begin
            r_div <= r_div - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_done  <= 2'b00;
          r_last  <= r_gnt[1];
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign count = r_count;
  assign done  = r_done;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_gray_counter_sched.sv
// Bench for gray_counter_sched: STEP_DIV=1 and STEP_DIV=3 instances share
// stimulus; a burst-level model is compared every cycle, plus directed literals.
module tb_gray_counter_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [2:0] len0, len1;
  logic [1:0] dir;

  logic [1:0] g1, d1, g3, d3;
  logic       b1, w1, b3, w3;
  logic [2:0] c1, c3;
  logic [8:0] obs [2];

  int n_err = 0;
  int n_checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  gray_counter_sched #(.STEP_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1), .dir(dir),
    .gnt(g1), .busy(b1), .count(c1), .done(d1), .wrap(w1)
  );

  gray_counter_sched #(.STEP_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1), .dir(dir),
    .gnt(g3), .busy(b3), .count(c3), .done(d3), .wrap(w3)
  );

  assign obs[0] = {g1, b1, c1, d1, w1};
  assign obs[1] = {g3, b3, c3, d3, w3};

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Burst-level model: position in the Gray sequence plus cycles since grant
  logic [2:0] SEQ [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  int DIVS [2] = '{1, 3};
  bit m_act [2], m_dir [2], m_last [2], m_wrap [2], m_done [2];
  int m_t [2], m_idx [2], m_len [2], m_g [2], m_end [2];

  initial for (int i = 0; i < 2; i++) begin
    m_act[i] = 0; m_idx[i] = 0; m_last[i] = 1; m_wrap[i] = 0; m_done[i] = 0;
    m_t[i] = 0; m_len[i] = 0; m_g[i] = 0; m_dir[i] = 0; m_end[i] = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_wrap[i] = 0;
      m_done[i] = 0;
      if (!rst_n) begin
        m_act[i] = 0; m_idx[i] = 0; m_last[i] = 1;
      end else if (m_act[i]) begin
        m_t[i]++;
        m_end[i] = (m_len[i] + 1) * DIVS[i];
        if (m_t[i] > m_end[i]) begin
          m_act[i] = 0;
          m_last[i] = (m_g[i] == 1);
        end else if (m_t[i] % DIVS[i] == 0) begin
          if (m_dir[i]) begin
            m_wrap[i] = (m_idx[i] == 0);
            m_idx[i] = (m_idx[i] + 7) % 8;
          end else begin
            m_wrap[i] = (m_idx[i] == 7);
            m_idx[i] = (m_idx[i] + 1) % 8;
          end
          m_done[i] = (m_t[i] == m_end[i]);
        end
      end else if (req != 2'b00) begin
        m_g[i] = (req == 2'b11) ? (m_last[i] ? 0 : 1) : (req[1] ? 1 : 0);
        m_act[i] = 1;
        m_t[i] = 0;
        m_len[i] = (m_g[i] == 1) ? int'(len1) : int'(len0);
        m_dir[i] = dir[m_g[i]];
      end
    end
  end

  logic [1:0] e_g, e_d;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        e_g = m_act[i] ? (2'b01 << m_g[i]) : 2'b00;
        e_d = m_done[i] ? (2'b01 << m_g[i]) : 2'b00;
        chk($sformatf("model[%0d] gnt", i),   9'(obs[i][8:7]), 9'(e_g));
        chk($sformatf("model[%0d] busy", i),  9'(obs[i][6]),   9'(m_act[i]));
        chk($sformatf("model[%0d] count", i), 9'(obs[i][5:3]), 9'(SEQ[m_idx[i]]));
        chk($sformatf("model[%0d] done", i),  9'(obs[i][2:1]), 9'(e_d));
        chk($sformatf("model[%0d] wrap", i),  9'(obs[i][0]),   9'(m_wrap[i]));
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 400; c++) begin
      if (!m_act[0] && !m_act[1]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_idle: burst still active after 400 cycles");
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] up30 [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [1:0] g31 [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
  logic [1:0] d31 [9] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
  logic [2:0] up35 [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};

  initial begin
    rst_n = 1'b0; req = 2'b00; len0 = 3'd0; len1 = 3'd0; dir = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("reset dut1", obs[0], 9'b0);
    chk("reset dut3", obs[1], 9'b0);

    // single requester, full 8-step up burst with wrap
    rst_n = 1'b1; req = 2'b01; len0 = 3'd7;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) req = 2'b00;
      if (k <= 8) begin
        chk($sformatf("t030 gnt k=%0d", k), 9'(g1), 9'(2'b01));
        chk($sformatf("t030 count k=%0d", k), 9'(c1), 9'(up30[k]));
        chk($sformatf("t030 wrap k=%0d", k), 9'(w1), 9'(k == 8));
        chk($sformatf("t030 done k=%0d", k), 9'(d1), (k == 8) ? 9'(2'b01) : 9'd0);
      end else begin
        chk("t030 release", 9'({g1, b1, d1}), 9'd0);
      end
    end
    wait_idle();

    // requester 1 counting down from 000
    req = 2'b10; dir = 2'b10; len1 = 3'd1;
    @(negedge clk);
    req = 2'b00;
    chk("t032 gnt", 9'(g1), 9'(2'b10));
    @(negedge clk);
    chk("t032 step1", 9'({c1, w1, d1}), 9'({3'b100, 1'b1, 2'b00}));
    @(negedge clk);
    chk("t032 step2", 9'({c1, w1, d1}), 9'({3'b101, 1'b0, 2'b10}));
    @(negedge clk);
    chk("t032 release", 9'(g1), 9'd0);
    wait_idle();

    // both requesting: alternating one-step bursts
    dir = 2'b00; len0 = 3'd0; len1 = 3'd0; req = 2'b11;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      chk($sformatf("t031 gnt n=%0d", n), 9'(g1), 9'(g31[n]));
      chk($sformatf("t031 done n=%0d", n), 9'(d1), 9'(d31[n]));
    end
    req = 2'b00;
    wait_idle();

    // STEP_DIV=3 pacing
    pulse_reset();
    req = 2'b01; len0 = 3'd2; dir = 2'b00;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (n == 0) req = 2'b00;
      chk($sformatf("t033 count n=%0d", n), 9'(c3),
          (n < 3) ? 9'd0 : (n < 6) ? 9'(3'b001) : (n < 9) ? 9'(3'b011) : 9'(3'b010));
      chk($sformatf("t033 done n=%0d", n), 9'(d3), (n == 9) ? 9'(2'b01) : 9'd0);
      chk($sformatf("t033 gnt n=%0d", n), 9'(g3), (n <= 9) ? 9'(2'b01) : 9'd0);
    end
    wait_idle();

    // reset during the 4th step of an 8-step burst
    pulse_reset();
    req = 2'b01; len0 = 3'd7; dir = 2'b00;
    @(negedge clk);
    req = 2'b00;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("t034 count n=%0d", n), 9'(c1), 9'(up30[n]));
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t034 abort", obs[0], 9'b0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk($sformatf("t034 no done n=%0d", n), 9'({g1, d1}), 9'd0);
    end
    wait_idle();

    // input changes during the burst are ignored
    req = 2'b01; len0 = 3'd3; len1 = 3'd5; dir = 2'b00;
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      if (n <= 4) begin
        chk($sformatf("t035 gnt n=%0d", n), 9'(g1), 9'(2'b01));
        chk($sformatf("t035 count n=%0d", n), 9'(c1), 9'(up35[n]));
        chk($sformatf("t035 done n=%0d", n), 9'(d1), (n == 4) ? 9'(2'b01) : 9'd0);
      end else begin
        chk("t035 release", 9'({g1, b1}), 9'd0);
      end
      case (n)
        0: begin req = 2'b10; len0 = 3'd0; dir = 2'b11; end
        1: req = 2'b11;
        2: req = 2'b10;
        3: req = 2'b11;
        default: req = 2'b00;
      endcase
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
